vote_button_conditioner: RTL and testbench

Front-end conditioning stage directly upstream of the voting machine core. It takes the four raw, asynchronous candidate push-buttons and the mode switch. It synchronises and debounces them, then arbitrates so that each accepted press yields exactly one single-cycle vote pulse on exactly one candidate line. Simultaneous or overlapping presses are rejected and flagged rather than forwarded.

---
 rtl/vote_button_conditioner.sv | 230 +++++++++++++++++++++++
 tb/tb_vote_button_conditioner.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_button_conditioner.sv
`timescale 1ns/1ps
// vote_button_conditioner
// Purpose : synchronise and debounce four raw candidate buttons plus the mode
//           switch, then arbitrate so each accepted press yields exactly one
//           single-cycle, one-hot vote pulse.
// Latency : raw edge captured at edge N -> vote_pulse high after edge
//           N+2+DEBOUNCE_CYCLES (plus HOLD_CYCLES with HOLD_REQUIRE_EN).
// Backpr. : none; a press overlapping another press is dropped and flagged on
//           multi_err, never queued.
// Ports   : clk        - system clock, all state on the rising edge
//           reset      - asynchronous, active-low (0 = in reset)
//           mode       - raw mode switch (synchronised only, not debounced)
//           button1..4 - raw candidate buttons, active-high
//           vote_pulse - one-hot single-cycle vote strobe, bit i-1 = button i
//           mode_sync  - mode after the two-flop synchroniser
//           busy       - high while the arbiter is not IDLE
//           multi_err  - single-cycle strobe when a press is rejected
// Config  : define HOLD_REQUIRE_EN to issue the pulse only after the owning
//           button has stayed held for HOLD_CYCLES debounced cycles.

module vote_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       button4,
  output logic [3:0] vote_pulse,
  output logic       mode_sync,
  output logic       busy,
  output logic       multi_err
);

  // Reject nonsensical configurations at elaboration time.
  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
    $error("vote_button_conditioner: DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 1");
  end

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers: bits [3:0] are buttons 1..4, bit [4] is mode.
  // ---------------------------------------------------------------------------
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic [3:0] btn_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {mode, button4, button3, button2, button1};
      sync2 <= sync1;
    end
  end

  assign btn_sync  = sync2[3:0];
  assign mode_sync = sync2[4];

  // ---------------------------------------------------------------------------
  // Debounce: the debounced level flips only after the synchronised input has
  // disagreed with it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing
  // cycle restarts the count, so short glitches are absorbed.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt [4];
  logic [3:0]    db;
  logic [3:0]    db_prev;
  logic [3:0]    rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
      db      <= '0;
      db_prev <= '0;
    end else begin
      db_prev <= db;
      for (int i = 0; i < 4; i++) begin
        if (btn_sync[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i] <= '0;
          db[i]  <= ~db[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise = db & ~db_prev;

  // ---------------------------------------------------------------------------
  // Arbiter decode.
  // The FSM only returns to IDLE with every debounced button low, so any
  // debounced-high bit seen in IDLE is rising in that very cycle.
  // ---------------------------------------------------------------------------
  logic multi_db;      // two or more debounced buttons high together
  logic single_press;  // exactly one button high and it has just risen

  assign multi_db     = (db & (db - 4'd1)) != 4'd0;
  assign single_press = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0) && (db == rise);

  state_t     state;
  state_t     state_next;
  logic [3:0] owner_oh;
  logic [3:0] owner_next;
  logic [3:0] pulse_next;
  logic       err_next;

`ifdef HOLD_REQUIRE_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HC_FIRE = HW'(HOLD_CYCLES - 1);
  // Saturation value: above HC_FIRE so it can never fire again.
  localparam logic [HW-1:0] HC_DONE = HW'(HOLD_CYCLES);

  logic [HW-1:0] hc;
  logic [HW-1:0] hc_next;
  logic          owner_held;

  assign owner_held = (db & owner_oh) != 4'd0;
`endif

  // ---------------------------------------------------------------------------
  // State register, including the registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner_oh   <= '0;
      vote_pulse <= '0;
      multi_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef HOLD_REQUIRE_EN
      hc         <= '0;
`endif
    end else begin
      state      <= state_next;
      owner_oh   <= owner_next;
      vote_pulse <= pulse_next;
      multi_err  <= err_next;
      // Registered from the next state so busy tracks (state != IDLE) exactly.
      busy       <= (state_next != IDLE);
`ifdef HOLD_REQUIRE_EN
      hc         <= hc_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (multi_db) begin
          state_next = LOCKOUT;
        end else if (single_press) begin
          state_next = HELD;
        end
      end
      HELD, LOCKOUT: begin
        if (db == 4'd0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (values loaded into the output registers on the next edge).
  // ---------------------------------------------------------------------------
  always_comb begin
    pulse_next = 4'b0000;
    err_next   = 1'b0;
    owner_next = owner_oh;
`ifdef HOLD_REQUIRE_EN
    hc_next    = hc;
`endif
    case (state)
      IDLE: begin
        if (multi_db) begin
          err_next = 1'b1;
        end else if (single_press) begin
          owner_next = rise;
`ifdef HOLD_REQUIRE_EN
          hc_next    = '0;
`else
          pulse_next = rise;
`endif
        end
      end
      HELD: begin
        // One strobe per intruding rise; the intruding press itself is dropped.
        if ((rise & ~owner_oh) != 4'd0) begin
          err_next = 1'b1;
        end
`ifdef HOLD_REQUIRE_EN
        // Releasing the owner early forfeits the vote for this visit, even if
        // it is pressed again while another button keeps the arbiter in HELD.
        if (!owner_held) begin
          hc_next = HC_DONE;
        end else if (hc == HC_FIRE) begin
          pulse_next = owner_oh;
          hc_next    = HC_DONE;
        end else if (hc != HC_DONE) begin
          hc_next = hc + HW'(1);
        end
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vote_button_conditioner.sv
`timescale 1ns/1ps
// Bench for vote_button_conditioner: table of press scenarios plus hand-written
// sequences for reset, mode synchronisation, busy timing and reset mid-press.
// Expected pulses / error strobes are queued with their due cycle when a
// stimulus is driven and consumed by a monitor when the DUT raises them.

module tb_vote_button_conditioner;

  localparam int D = 4;
  localparam int H = 16;
`ifdef HOLD_REQUIRE_EN
  localparam bit HOLD_MODE = 1'b1;
`else
  localparam bit HOLD_MODE = 1'b0;
`endif
  // Drive at a falling edge with cyc == t: capture edge is t+1, the debounced
  // level flips on edge t+1+1+D, the arbiter registers its output one edge
  // later, so the strobe is seen at the falling edge where cyc == t+3+D.
  localparam int PRESS_LAT = 3 + D;
  localparam int PULSE_LAT = PRESS_LAT + (HOLD_MODE ? H : 0);

  logic       clk = 1'b0;
  logic       reset;
  logic       mode;
  logic [3:0] buttons;
  logic       button1, button2, button3, button4;
  logic [3:0] vote_pulse;
  logic       mode_sync;
  logic       busy;
  logic       multi_err;

  assign button1 = buttons[0];
  assign button2 = buttons[1];
  assign button3 = buttons[2];
  assign button4 = buttons[3];

  vote_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .button1   (button1),
    .button2   (button2),
    .button3   (button3),
    .button4   (button4),
    .vote_pulse(vote_pulse),
    .mode_sync (mode_sync),
    .busy      (busy),
    .multi_err (multi_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } ev_t;

  ev_t pulse_q[$];
  int  err_q[$];
  bit  busy_seen;

  // Scoreboard monitor.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (busy) busy_seen = 1'b1;
    if (vote_pulse != 4'b0000) begin
      check("pulse_onehot", 32'($onehot(vote_pulse)), 32'd1);
      if (pulse_q.size() == 0) begin
        check("pulse_unexpected", {28'd0, vote_pulse}, 32'd0);
      end else begin
        e = pulse_q.pop_front();
        check("pulse_value", {28'd0, vote_pulse}, {28'd0, e.val});
        check("pulse_cycle", cyc, e.cyc);
      end
    end
    if (multi_err) begin
      if (err_q.size() == 0) begin
        check("err_unexpected", {31'd0, multi_err}, 32'd0);
      end else begin
        check("err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_pulse(input logic [3:0] val, input int due);
    ev_t e;
    e.cyc = due;
    e.val = val;
    pulse_q.push_back(e);
  endtask

  task automatic drain_check(input string name);
    check($sformatf("%s_pulse_pending", name), pulse_q.size(), 32'd0);
    check($sformatf("%s_err_pending", name), err_q.size(), 32'd0);
    pulse_q.delete();
    err_q.delete();
  endtask

  typedef struct {
    string      name;
    logic [3:0] first;      // buttons raised at t0
    logic [3:0] second;     // buttons added at t0+second_at (0 = none)
    int         second_at;
    int         hold;       // raw cycles before all buttons drop
    logic [3:0] exp_pulse;  // vote expected for the first press (0 = none)
    bit         err_first;  // multi_err from the first press
    bit         err_second; // multi_err from the second press
    bit         exp_busy;   // arbiter expected to leave IDLE
  } vec_t;

  vec_t vecs[13];

  task automatic run_vec(input vec_t v);
    int t0;
    t0 = cyc;
    busy_seen = 1'b0;
    buttons = v.first;
    // With hold-to-vote the debounced level lasts as long as the raw press;
    // the owner must still be high on the edge that ends its H-th held cycle
    // after entering HELD, i.e. a raw press of more than H cycles.
    if (v.exp_pulse != 4'b0000 && (!HOLD_MODE || v.hold > H))
      push_pulse(v.exp_pulse, t0 + PULSE_LAT);
    if (v.err_first) err_q.push_back(t0 + PRESS_LAT);
    for (int k = 1; k <= v.hold; k++) begin
      tick(1);
      if (k == v.hold) begin
        buttons = 4'b0000;
      end else if (v.second != 4'b0000 && k == v.second_at) begin
        buttons = buttons | v.second;
        if (v.err_second) err_q.push_back(cyc + PRESS_LAT);
      end
    end
    tick(12);
    check($sformatf("%s_busy_seen", v.name), {31'd0, busy_seen}, {31'd0, v.exp_busy});
    check($sformatf("%s_idle_after", v.name), {31'd0, busy}, 32'd0);
    drain_check(v.name);
  endtask

  initial begin
    int t0;
    int r;

    vecs[0]  = '{"b2_press",        4'b0010, 4'b0000,  0, 20, 4'b0010, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{"b1_glitch2",      4'b0001, 4'b0000,  0,  2, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"b1_glitch_dm1",   4'b0001, 4'b0000,  0,  3, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"b1_min_press",    4'b0001, 4'b0000,  0,  4, 4'b0001, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{"b34_same_edge",   4'b1100, 4'b0000,  0, 20, 4'b0000, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{"b3_after_lock",   4'b0100, 4'b0000,  0, 20, 4'b0100, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{"b1_then_b2",      4'b0001, 4'b0010, 10, 30, 4'b0001, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{"lock_then_b1",    4'b1100, 4'b0001, 10, 20, 4'b0000, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{"b4_short",        4'b1000, 4'b0000,  0, 10, 4'b1000, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{"b4_long",         4'b1000, 4'b0000,  0, 30, 4'b1000, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{"b2_hold_h",       4'b0010, 4'b0000,  0, 16, 4'b0010, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{"b2_hold_h1",      4'b0010, 4'b0000,  0, 17, 4'b0010, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{"three_same_edge", 4'b0111, 4'b0000,  0,  8, 4'b0000, 1'b1, 1'b0, 1'b1};

    // Reset held for 10 cycles, then released with all inputs low.
    reset   = 1'b0;
    mode    = 1'b0;
    buttons = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("reset_outputs", {25'd0, vote_pulse, mode_sync, busy, multi_err}, 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("idle_outputs", {25'd0, vote_pulse, mode_sync, busy, multi_err}, 32'd0);
    end

    // Mode goes through two flops, no debounce.
    mode = 1'b1;
    tick(1);
    check("mode_sync_stage1", {31'd0, mode_sync}, 32'd0);
    tick(1);
    check("mode_sync_rise", {31'd0, mode_sync}, 32'd1);
    mode = 1'b0;
    tick(1);
    check("mode_sync_hold", {31'd0, mode_sync}, 32'd1);
    tick(1);
    check("mode_sync_fall", {31'd0, mode_sync}, 32'd0);
    tick(4);

    // button2 held 20 cycles: busy edges at exact cycles around press/release.
    t0 = cyc;
    buttons = 4'b0010;
    push_pulse(4'b0010, t0 + PULSE_LAT);
    tick(PRESS_LAT - 1);
    check("busy_before_entry", {31'd0, busy}, 32'd0);
    tick(1);
    check("busy_on_entry", {31'd0, busy}, 32'd1);
    tick(20 - PRESS_LAT);
    buttons = 4'b0000;
    tick(PRESS_LAT - 1);
    check("busy_before_exit", {31'd0, busy}, 32'd1);
    tick(1);
    check("busy_after_exit", {31'd0, busy}, 32'd0);
    tick(5);
    drain_check("busy_seq");

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i]);
    end

    // Reset in the middle of a press: nothing comes out; the still-held
    // button is then accepted as a fresh press once reset releases.
    t0 = cyc;
    buttons = 4'b1000;
    tick(HOLD_MODE ? 12 : 5);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("midreset_outputs", {25'd0, vote_pulse, mode_sync, busy, multi_err}, 32'd0);
    end
    reset = 1'b1;
    r = cyc;
    push_pulse(4'b1000, r + PULSE_LAT);
    tick(25);
    buttons = 4'b0000;
    tick(12);
    check("midreset_idle", {31'd0, busy}, 32'd0);
    drain_check("midreset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
